// File: rtl/muldiv_pkg.sv
`default_nettype none
// muldiv_pkg: shared encodings for the RV32M multiply/divide unit.
// Rev 1.0
package muldiv_pkg;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// muldiv_iter_core: one-bit-per-step shift-add multiply / restoring divide on magnitudes.
// Rev 1.0
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic                 is_mul,
   input  logic [WIDTH-1:0]     mag_a,
   input  logic [WIDTH-1:0]     mag_b,
   output logic [2*WIDTH-1:0]   acc
);

   logic [WIDTH-1:0]   opb;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] acc_next;

   // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
   // Divide: high half is the running remainder, low half shifts dividend out / quotient in.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      diff      = rem_shift - {1'b0, opb};
      if (is_mul) begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         opb <= '0;
      end else if (load) begin
         acc <= {{WIDTH{1'b0}}, mag_a};
         opb <= mag_b;
      end else if (step) begin
         acc <= acc_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// muldiv_unit: multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with valid/ready.
// Rev 1.0
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int               CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state;
   logic [CNT_W-1:0]   iter;
   logic [2:0]         op_q;
   logic               neg_q;   // product / quotient needs negation
   logic               neg_r;   // remainder takes the dividend's sign

   logic               accept;
   logic               step;
   logic               a_signed;
   logic               b_signed;
   logic               a_neg;
   logic               b_neg;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   special_res;
   logic [WIDTH-1:0]   fix_res;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] prod;

   assign accept = (state == ST_IDLE) && in_valid && !kill;
   assign step   = (state == ST_CALC) && !kill;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (funct3)
         F3_MULH, F3_DIV, F3_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         F3_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
   end

   assign a_neg    = a_signed && op_a[WIDTH-1];
   assign b_neg    = b_signed && op_b[WIDTH-1];
   assign mag_a    = a_neg ? -op_a : op_a;
   assign mag_b    = b_neg ? -op_b : op_b;

   assign div_zero = funct3[2] && (op_b == '0);
   assign div_ovf  = funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);

   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = funct3[1] ? op_a : '1;
      end else if (div_ovf) begin
         special_res = funct3[1] ? '0 : op_a;
      end
   end

   assign prod = neg_q ? -acc : acc;
   assign quo  = acc[WIDTH-1:0];
   assign rem  = acc[2*WIDTH-1:WIDTH];

   always_comb begin
      fix_res = '0;
      if (!op_q[2]) begin
         fix_res = (op_q == F3_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      end else if (op_q[1]) begin
         fix_res = neg_r ? -rem : rem;
      end else begin
         fix_res = neg_q ? -quo : quo;
      end
   end

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   (step),
      .is_mul (!op_q[2]),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .acc    (acc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         iter      <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
      end else if (kill) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q     <= funct3;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  iter     <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (div_zero || div_ovf) begin
                     result    <= special_res;
                     out_valid <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               iter <= iter + 1'b1;
               if (iter == LAST_ITER) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               result    <= fix_res;
               out_valid <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// tb_muldiv_unit: randomized bench against an arithmetic RV32M reference model.
// Rev 1.0
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int          W          = 32;
   localparam int          LAT_NORMAL = W + 2;
   localparam logic [W-1:0] MIN_NEG   = 32'h8000_0000;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         in_valid  = 1'b0;
   logic         kill      = 1'b0;
   logic         out_ready = 1'b0;
   logic [2:0]   funct3    = 3'b000;
   logic [W-1:0] op_a      = '0;
   logic [W-1:0] op_b      = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [W-1:0] result;

   int checks   = 0;
   int failures = 0;

   // reference state: one operation in flight, its age in cycles and required latency
   bit           inflight = 1'b0;
   int           age      = 0;
   int           lat      = 0;
   logic [W-1:0] exp_res  = '0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct3    (funct3),
      .op_a      (op_a),
      .op_b      (op_b),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint     sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = '0;
      case (f3)
         F3_MUL:    begin p = ua * ub; return p[W-1:0]; end
         F3_MULH:   begin p = sa * sb; return p[63:32]; end
         F3_MULHSU: begin p = sa * ub; return p[63:32]; end
         F3_MULHU:  begin p = ua * ub; return p[63:32]; end
         F3_DIV: begin
            if (b == '0) return '1;
            if (a == MIN_NEG && b == '1) return a;
            p = sa / sb;
            return p[W-1:0];
         end
         F3_REM: begin
            if (b == '0) return a;
            if (a == MIN_NEG && b == '1) return '0;
            p = sa % sb;
            return p[W-1:0];
         end
         F3_DIVU: begin
            if (b == '0) return '1;
            p = ua / ub;
            return p[W-1:0];
         end
         default: begin
            if (b == '0) return a;
            p = ua % ub;
            return p[W-1:0];
         end
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
      return f3[2] && ((b == '0) || (!f3[0] && a == MIN_NEG && b == '1));
   endfunction

   // reference timeline, advanced on the same edges as the DUT
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight = 1'b0;
         age      = 0;
      end else if (kill) begin
         inflight = 1'b0;
      end else if (inflight) begin
         if (age >= lat && out_ready) inflight = 1'b0;
         else age++;
      end else if (in_valid) begin
         exp_res  = model(funct3, op_a, op_b);
         lat      = is_fast(funct3, op_a, op_b) ? 1 : LAT_NORMAL;
         age      = 1;
         inflight = 1'b1;
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         check("in_ready", 64'(in_ready), 64'(!inflight));
         check("busy", 64'(busy), 64'(inflight));
         check("out_valid", 64'(out_valid), 64'(inflight && age >= lat));
         if (inflight && age >= lat) check("result", 64'(result), 64'(exp_res));
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (inflight && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 64'(inflight), 64'd0);
   endtask

   task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1;
      funct3   = f3;
      op_a     = a;
      op_b     = b;
      @(negedge clk);
      in_valid = 1'b0;
      funct3   = 3'($urandom_range(0, 7));
      op_a     = $urandom;
      op_b     = $urandom;
   endtask

   task automatic finish_op(input int hold);
      int n = 0;
      while (!(inflight && age >= lat) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("result_timeout", 64'(inflight && age >= lat), 64'd1);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
      wait_idle();
      issue(f3, a, b);
      finish_op(hold);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [2:0]   rf3;
      logic [W-1:0] ra, rb;

      check("pin_mul",    64'(model(F3_MUL,    32'd7,        32'hFFFFFFFD)), 64'hFFFFFFEB);
      check("pin_mulh",   64'(model(F3_MULH,   32'h80000000, 32'h80000000)), 64'h40000000);
      check("pin_mulhu",  64'(model(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF)), 64'hFFFFFFFE);
      check("pin_mulhsu", 64'(model(F3_MULHSU, 32'hFFFFFFFF, 32'd2)),        64'hFFFFFFFF);
      check("pin_div",    64'(model(F3_DIV,    32'hFFFFFFF9, 32'd2)),        64'hFFFFFFFD);
      check("pin_rem",    64'(model(F3_REM,    32'hFFFFFFF9, 32'd2)),        64'hFFFFFFFF);
      check("pin_divu",   64'(model(F3_DIVU,   32'hFFFFFFF9, 32'd2)),        64'h7FFFFFFC);
      check("pin_remu",   64'(model(F3_REMU,   32'hFFFFFFF9, 32'd2)),        64'h1);
      check("pin_div0",   64'(model(F3_DIV,    32'd5,        32'd0)),        64'hFFFFFFFF);
      check("pin_remu0",  64'(model(F3_REMU,   32'd5,        32'd0)),        64'h5);
      check("pin_divovf", 64'(model(F3_DIV,    32'h80000000, 32'hFFFFFFFF)), 64'h80000000);
      check("pin_removf", 64'(model(F3_REM,    32'h80000000, 32'hFFFFFFFF)), 64'h0);

      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result",    64'(result),    64'd0);
      #2 rst = 1'b1;

      run_op(F3_MUL,    32'd7,        32'hFFFFFFFD, 0);
      run_op(F3_MULH,   32'h80000000, 32'h80000000, 0);
      run_op(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 1);
      run_op(F3_MULHSU, 32'hFFFFFFFF, 32'd2,        0);
      run_op(F3_DIV,    32'hFFFFFFF9, 32'd2,        0);
      run_op(F3_REM,    32'hFFFFFFF9, 32'd2,        2);
      run_op(F3_DIVU,   32'hFFFFFFF9, 32'd2,        0);
      run_op(F3_REMU,   32'hFFFFFFF9, 32'd2,        0);
      run_op(F3_DIV,    32'd5,        32'd0,        0);
      run_op(F3_REMU,   32'd5,        32'd0,        1);
      run_op(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 0);
      run_op(F3_REM,    32'h80000000, 32'hFFFFFFFF, 0);

      // backpressure with the next request already waiting on in_valid
      wait_idle();
      in_valid = 1'b1;
      funct3   = F3_MULHSU;
      op_a     = 32'h8765_4321;
      op_b     = 32'h0000_1234;
      @(negedge clk);
      funct3   = F3_DIVU;
      op_a     = 32'd1000;
      op_b     = 32'd7;
      n = 0;
      while (!(inflight && age >= lat) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_timeout", 64'(inflight && age >= lat), 64'd1);
      repeat (5) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid  = 1'b0;
      finish_op(0);

      // kill in IDLE blocks the accept
      wait_idle();
      in_valid = 1'b1;
      kill     = 1'b1;
      funct3   = F3_MUL;
      @(negedge clk);
      in_valid = 1'b0;
      kill     = 1'b0;
      @(negedge clk);

      // kill mid-calculation, then a clean operation
      wait_idle();
      issue(F3_DIV, 32'd12345, 32'd17);
      n = 0;
      while (age < 10 && n < 50) begin
         @(negedge clk);
         n++;
      end
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      repeat (40) @(negedge clk);
      run_op(F3_REM, 32'hFFFF_FF00, 32'd9, 0);

      // asynchronous reset mid-operation
      wait_idle();
      issue(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
      n = 0;
      while (age < 20 && n < 50) begin
         @(negedge clk);
         n++;
      end
      #2 rst = 1'b0;
      #1;
      check("amid_out_valid", 64'(out_valid), 64'd0);
      check("amid_busy",      64'(busy),      64'd0);
      check("amid_result",    64'(result),    64'd0);
      check("amid_in_ready",  64'(in_ready),  64'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      run_op(F3_MUL, 32'd123456, 32'd654321, 0);

      for (int i = 0; i < 60; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 9))
            0: rb = '0;
            1: begin ra = MIN_NEG; rb = '1; end
            2: ra = '1;
            3: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(rf3, ra, rb, $urandom_range(0, 3));
      end

      wait_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle RV32M multiply/divide unit: it executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on `WIDTH`-bit operands. It sits beside the single-cycle execution unit and is selected for `OPCODE_MULDIV` instructions with funct7 = 0000001. It accepts one operation through a valid/ready handshake, iterates one bit per cycle, and holds its result until the consumer takes it. The CPU stalls its PC while the unit is busy.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operation request.
- `in_ready`  output  1  unit can accept an operation; high only in IDLE.
- `funct3`  input  3  RV32M selector: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  WIDTH  rs1 value.
- `op_b`  input  WIDTH  rs2 value.
- `kill`  input  1  abort the in-flight operation.
- `out_valid`  output  1  `result` valid.
- `out_ready`  input  1  consumer takes the result.
- `result`  output  WIDTH  rd value.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- Operands, `funct3` and the sign flags are captured on the accept cycle (`in_valid && in_ready`). Inputs are ignored after that cycle.
- States and transitions:
  - IDLE → CALC on accept.
  - IDLE → DONE on accept of a special division case.
  - CALC → FIX after `WIDTH` iterations.
  - FIX → DONE.
  - DONE → IDLE when `out_ready` is high.
- Multiply:
  - Operands are converted to magnitudes according to their signedness: MULH both signed; MULHSU a signed, b unsigned; MUL and MULHU both unsigned.
  - Shift-add into a 2·`WIDTH` accumulator.
  - FIX negates the product if the operand signs differ, then selects the low half (MUL) or the high half (the others).
- Divide:
  - Restoring divide on magnitudes, `WIDTH` iterations.
  - FIX negates the quotient if the signs differ (DIV), and gives the remainder the dividend's sign (REM).
- Special cases take the fast path and skip CALC and FIX:
  - Divisor zero: quotient = all ones; remainder = `op_a`.
  - Signed overflow (`op_a` = most-negative value, `op_b` = −1, DIV/REM only): quotient = `op_a`; remainder = 0.
- `kill` has priority over every transition. In CALC, FIX or DONE it forces IDLE on the next edge; `out_valid` drops with it and no result is delivered. `kill` in IDLE blocks an accept in the same cycle.
- `result` and `out_valid` are stable while `out_valid && !out_ready`.
- Reset, at any time including mid-operation, immediately forces:
  - state IDLE, `in_ready` = 1, `busy` = 0
  - `out_valid` = 0, `result` = 0
  - internal accumulators cleared.

## Timing
- The accept edge is cycle 0.
- Normal operation: CALC occupies cycles 1…`WIDTH`, FIX is cycle `WIDTH`+1, and `out_valid` rises at cycle `WIDTH`+2. For `WIDTH` = 32 that is cycle 34.
- Fast path: `out_valid` at cycle 1.
- The result handshake completes on the edge where `out_valid && out_ready`. `in_ready` rises on the following cycle, so there is no same-cycle re-accept. Minimum spacing between accepts is `WIDTH`+3 cycles.
- `in_ready`, `busy` and `out_valid` are decoded from the registered state only. They never depend combinationally on `in_valid` or `out_ready`.

## Structure
- Shared package `muldiv_pkg` holds:
  - the funct3 encodings as named constants
  - the state encoding (IDLE, CALC, FIX, DONE)
  - `FUNCT7_MULDIV` = 7'b0000001.
- One sub-module, `muldiv_iter_core`, holds the shift-add/restoring datapath. It takes operand magnitudes, a mul/div flag and a step enable, and returns the 2·`WIDTH` accumulator.
- The top level holds the handshake and FSM, the iteration counter (width $clog2(`WIDTH`+1)), sign handling and the special-case detect.

## Test plan
All scenarios use `WIDTH` = 32.
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB. `out_valid` at cycle 34, `busy` high on cycles 1–34.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divides on 0xFFFFFFF9 ÷ 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
- Special cases, each with `out_valid` at cycle 1:
  - DIV 5÷0 → 0xFFFFFFFF.
  - REMU 5÷0 → 5.
  - DIV 0x80000000÷0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold `out_ready` low for 5 cycles after `out_valid`. `result` stays constant throughout. `in_ready` is low until the cycle after the handshake. `in_valid` held high throughout is not accepted early.
- Abort paths:
  - `kill` at cycle 10 → `in_ready` = 1 at cycle 11, no `out_valid` ever; the next operation computes correctly.
  - `rst` low at cycle 20 → `out_valid` = 0, `busy` = 0, `result` = 0 immediately.
